// File: rtl/neuron_pkg.sv
// Shared definitions for the perceptron training controller: state encoding and
// the default epoch counter width.
package neuron_pkg;

    localparam int EPOCH_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_INIT        = 3'd1,
        S_EPOCH_START = 3'd2,
        S_TEST        = 3'd3,
        S_FETCH       = 3'd4,
        S_EVAL        = 3'd5,
        S_DONE        = 3'd6
    } state_t;

endpackage

// File: rtl/neuron_epoch_counter.sv
// Epoch counter: synchronous clear, saturating increment.
module neuron_epoch_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/neuron_ctrl.sv
// Perceptron training controller: sequences sample fetch, evaluation and weight
// updates per epoch. Optional epoch limit enabled by NEURON_CTRL_EPOCH_LIMIT_EN.
module neuron_ctrl
    import neuron_pkg::*;
#(
    parameter int EPOCH_W = EPOCH_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               sampleValid,
    output logic               sampleReady,
    output logic               sampleRewind,
    input  logic               yEqualt,
    input  logic               endFlag,
    input  logic               flagEOF,
`ifdef NEURON_CTRL_EPOCH_LIMIT_EN
    input  logic [EPOCH_W-1:0] maxEpoch,
`endif
    output logic               reset,
    output logic               nReset,
    output logic               counterReset,
    output logic               flagReset,
    output logic               counterEn,
    output logic               ldRegN,
    output logic               ldRegx1,
    output logic               ldRegx2,
    output logic               ldRegT,
    output logic               ldRegW1,
    output logic               ldRegW2,
    output logic               ldRegB,
    output logic               ldRegFlag,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               timeout,
    output logic [EPOCH_W-1:0] epochs
);

    state_t r_state;
    logic   r_converged;
    logic   r_timeout;
    logic   r_nReset;
    logic   w_limit;
    logic   w_ep_clr;
    logic   w_ep_inc;

`ifdef NEURON_CTRL_EPOCH_LIMIT_EN
    logic [EPOCH_W-1:0] w_ep_next;
    assign w_ep_next = epochs + 1'b1;
    // maxEpoch of zero disables the limit.
    assign w_limit   = (maxEpoch != '0) && (w_ep_next == maxEpoch);
`else
    assign w_limit   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_converged <= 1'b0;
            r_timeout   <= 1'b0;
            r_nReset    <= 1'b0;
        end else begin
            r_nReset <= abort;
            if (abort) begin
                r_state     <= S_IDLE;
                r_converged <= 1'b0;
                r_timeout   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE:        if (start) r_state <= S_INIT;
                    S_INIT: begin
                        r_converged <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_state     <= S_EPOCH_START;
                    end
                    S_EPOCH_START: r_state <= S_TEST;
                    S_TEST: begin
                        // An epoch with no misclassification ends the run.
                        if (!flagEOF) begin
                            r_state <= S_FETCH;
                        end else if (!endFlag) begin
                            r_state     <= S_DONE;
                            r_converged <= 1'b1;
                        end else if (w_limit) begin
                            r_state   <= S_DONE;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state <= S_EPOCH_START;
                        end
                    end
                    S_FETCH:       if (sampleValid) r_state <= S_EVAL;
                    S_EVAL:        r_state <= S_TEST;
                    S_DONE:        if (start) r_state <= S_INIT;
                    default:       r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_ep_clr = abort || (r_state == S_INIT);
    assign w_ep_inc = (r_state == S_TEST) && flagEOF;

    neuron_epoch_counter #(.W(EPOCH_W)) u_epoch_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_ep_clr),
        .i_inc (w_ep_inc),
        .o_cnt (epochs)
    );

    // Strobes decode the registered state, so rst drops them in the same cycle.
    assign reset        = (r_state == S_INIT);
    assign ldRegN       = (r_state == S_INIT);
    assign counterReset = (r_state == S_INIT) || (r_state == S_EPOCH_START);
    assign flagReset    = (r_state == S_INIT) || (r_state == S_EPOCH_START);
    assign sampleRewind = (r_state == S_EPOCH_START);
    assign sampleReady  = (r_state == S_FETCH);
    assign ldRegx1      = (r_state == S_FETCH) && sampleValid;
    assign ldRegx2      = (r_state == S_FETCH) && sampleValid;
    assign ldRegT       = (r_state == S_FETCH) && sampleValid;
    assign ldRegFlag    = (r_state == S_EVAL);
    assign counterEn    = (r_state == S_EVAL);
    assign ldRegW1      = (r_state == S_EVAL) && !yEqualt;
    assign ldRegW2      = (r_state == S_EVAL) && !yEqualt;
    assign ldRegB       = (r_state == S_EVAL) && !yEqualt;
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done         = (r_state == S_DONE);
    assign converged    = r_converged;
    assign timeout      = r_timeout;
    assign nReset       = r_nReset;

endmodule
